// File: rtl/lab3_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// lab3_sweep_ctrl
//   Self-test sequencer for the 3-input / 2-output lab circuit. On a start
//   rising edge it walks {a,b,c} through 0..7 (a = MSB), holds each vector
//   for SETTLE_CYCLES clocks, samples x/y for one cycle, stores the samples
//   and compares them against the golden truth tables GOLD_X / GOLD_Y.
//
//   Build option: define SWEEP_LOOP_EN to repeat sweeps back-to-back while
//   start is held high (checked in the FINISH cycle). Without it, each start
//   rising edge runs exactly one sweep.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   start       in   sweep request (rising edge detected internally)
//   dut_a/b/c   out  circuit inputs, {a,b,c} = current vector index
//   dut_x/y     in   circuit outputs (same clock domain, combinational)
//   busy        out  sweep in progress
//   done        out  one-cycle pulse at end of each sweep
//   pass        out  last completed sweep matched golden tables
//   res_x/res_y out  captured x/y, bit i = vector i
//   fail_cnt    out  number of mismatching vectors (0..8)
//   first_fail  out  lowest mismatching vector index (0 if none)
// -----------------------------------------------------------------------------
module lab3_sweep_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] GOLD_X        = 8'hA9,
  parameter logic [7:0] GOLD_Y        = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_x,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] res_x,
  output logic [7:0] res_y,
  output logic [3:0] fail_cnt,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_FINISH} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [7:0] cnt_q;
  logic       start_q;
  logic [2:0] abc_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] res_x_q;
  logic [7:0] res_y_q;
  logic [3:0] fail_cnt_q;
  logic [2:0] first_fail_q;

  logic       start_rise;
  logic       mism;
  logic [3:0] fail_cnt_d;

  // The mismatch and the incremented count are formed combinationally so that
  // pass can be registered from the final count on the same edge that enters
  // FINISH, making it valid together with the done pulse.
  always_comb begin
    start_rise = start & ~start_q;
    mism       = (dut_x != GOLD_X[idx_q]) || (dut_y != GOLD_Y[idx_q]);
    fail_cnt_d = fail_cnt_q + {3'b000, mism};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 8'd0;
      start_q      <= 1'b0;
      abc_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      res_x_q      <= 8'h00;
      res_y_q      <= 8'h00;
      fail_cnt_q   <= 4'd0;
      first_fail_q <= 3'd0;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q      <= S_DRIVE;
            idx_q        <= 3'd0;
            cnt_q        <= 8'd0;
            abc_q        <= 3'd0;
            busy_q       <= 1'b1;
            fail_cnt_q   <= 4'd0;
            first_fail_q <= 3'd0;
          end
        end
        S_DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          res_x_q[idx_q] <= dut_x;
          res_y_q[idx_q] <= dut_y;
          if (mism) begin
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_q == 4'd0) first_fail_q <= idx_q;
          end
          if (idx_q == 3'd7) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == 4'd0);
`ifndef SWEEP_LOOP_EN
            busy_q  <= 1'b0;
`endif
          end else begin
            idx_q   <= idx_q + 3'd1;
            abc_q   <= idx_q + 3'd1;
            state_q <= S_DRIVE;
          end
        end
        S_FINISH: begin
`ifdef SWEEP_LOOP_EN
          // Start level (not edge) keeps the sweep running back-to-back;
          // busy only drops on the way back to IDLE.
          if (start) begin
            state_q      <= S_DRIVE;
            idx_q        <= 3'd0;
            cnt_q        <= 8'd0;
            abc_q        <= 3'd0;
            fail_cnt_q   <= 4'd0;
            first_fail_q <= 3'd0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_a      = abc_q[2];
  assign dut_b      = abc_q[1];
  assign dut_c      = abc_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign res_x      = res_x_q;
  assign res_y      = res_y_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

endmodule
